// File: rtl/jxx_pred_pc_ctrl.sv
// rtl/jxx_pred_pc_ctrl.sv - Y86 fetch-stage PC predictor with 2-bit BHT for jXX.
// Owns F_predPC, trains the BHT from M-stage resolution, and flags mispredicts.
module jxx_pred_pc_ctrl #(
   parameter int          IDX_W    = 6,
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        F_stall_i,
   input  logic [63:0] f_pc_i,
   input  logic [3:0]  f_icode_i,
   input  logic [63:0] f_valC_i,
   input  logic [63:0] f_valP_i,
   output logic        f_pred_taken_o,
   output logic [63:0] F_predPC_o,
   input  logic [3:0]  M_icode_i,
   input  logic        M_Cnd_i,
   input  logic [63:0] M_pc_i,
   input  logic        M_pred_taken_i,
   input  logic [63:0] M_valC_i,
   input  logic [63:0] M_valA_i,
   output logic        M_mispred_o,
   output logic [63:0] M_redirect_pc_o,
   output logic [31:0] br_cnt_o,
   output logic [31:0] mispred_cnt_o
);

   localparam int         DEPTH = 1 << IDX_W;
   localparam logic [3:0] IJXX  = 4'h7;
   localparam logic [3:0] ICALL = 4'h8;
   localparam logic [1:0] CTR_WEAK_T = 2'd2;
   localparam logic [1:0] CTR_MAX    = 2'd3;
   localparam logic [1:0] CTR_MIN    = 2'd0;
   localparam logic [31:0] STAT_MAX  = 32'hFFFF_FFFF;

   logic [1:0]       bht [DEPTH];
   logic [IDX_W-1:0] f_idx;
   logic [IDX_W-1:0] m_idx;
   logic             f_is_jxx;
   logic             f_is_call;
   logic             m_is_jxx;
   logic             pred_taken;
   logic             mispred;
   logic [1:0]       m_ctr;
   logic [1:0]       m_ctr_next;
   logic [63:0]      next_pred;
   logic [63:0]      pred_pc_q;
   logic [31:0]      br_cnt_q;
   logic [31:0]      mispred_cnt_q;
   logic             unused_pc_bits;

   // Byte-granular indexing; upper PC bits intentionally alias.
   assign f_idx          = f_pc_i[IDX_W-1:0];
   assign m_idx          = M_pc_i[IDX_W-1:0];
   assign unused_pc_bits = ^{f_pc_i[63:IDX_W], M_pc_i[63:IDX_W]};

   assign f_is_jxx  = (f_icode_i == IJXX);
   assign f_is_call = (f_icode_i == ICALL);
   assign m_is_jxx  = (M_icode_i == IJXX);

   // Fetch reads the pre-update entry; a same-cycle write lands next cycle.
   assign pred_taken = f_is_jxx & bht[f_idx][1];
   assign m_ctr      = bht[m_idx];

   always_comb begin
      next_pred = f_valP_i;
      if (f_is_call || pred_taken) begin
         next_pred = f_valC_i;
      end
   end

   always_comb begin
      m_ctr_next = m_ctr;
      if (M_Cnd_i) begin
         if (m_ctr != CTR_MAX) begin
            m_ctr_next = m_ctr + 2'd1;
         end
      end else begin
         if (m_ctr != CTR_MIN) begin
            m_ctr_next = m_ctr - 2'd1;
         end
      end
   end

   assign mispred = m_is_jxx & (M_Cnd_i != M_pred_taken_i);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            bht[i] <= CTR_WEAK_T;
         end
      end else if (m_is_jxx) begin
         bht[m_idx] <= m_ctr_next;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pred_pc_q <= RESET_PC;
      end else if (!F_stall_i) begin
         pred_pc_q <= next_pred;
      end
   end

   // Statistics run regardless of fetch stalls and stick at all-ones.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         br_cnt_q      <= '0;
         mispred_cnt_q <= '0;
      end else begin
         if (m_is_jxx && (br_cnt_q != STAT_MAX)) begin
            br_cnt_q <= br_cnt_q + 32'd1;
         end
         if (mispred && (mispred_cnt_q != STAT_MAX)) begin
            mispred_cnt_q <= mispred_cnt_q + 32'd1;
         end
      end
   end

   assign f_pred_taken_o  = pred_taken;
   assign F_predPC_o      = pred_pc_q;
   assign M_mispred_o     = mispred;
   assign M_redirect_pc_o = M_Cnd_i ? M_valC_i : M_valA_i;
   assign br_cnt_o        = br_cnt_q;
   assign mispred_cnt_o   = mispred_cnt_q;

endmodule

// File: doc/jxx_pred_pc_ctrl.md
Name: jxx_pred_pc_ctrl

Overview:
- Fetch-stage PC prediction controller for the Y86 pipeline.
- Owns the F_predPC register and a direct-mapped branch history table (BHT) of 2-bit saturating counters.
- Predicts jXX direction at fetch and trains the table when the jump resolves in M.
- Supplies F_predPC to the PC-select mux, plus a mispredict flag and recovery PC for the M-stage redirect and squash logic.

Parameters:
- IDX_W, 6: BHT index width; table depth is 2^IDX_W entries.
- RESET_PC, 64'h0: value loaded into F_predPC on reset.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- F_stall_i  in  1  fetch stall; holds F_predPC.
- f_pc_i  in  64  PC selected for the current fetch.
- f_icode_i  in  4  icode of the fetched instruction.
- f_valC_i  in  64  fetched constant (jump/call target).
- f_valP_i  in  64  fall-through PC.
- f_pred_taken_o  out  1  prediction for the fetched jXX; piped down to M.
- F_predPC_o  out  64  registered predicted PC.
- M_icode_i  in  4  icode in M.
- M_Cnd_i  in  1  resolved condition in M.
- M_pc_i  in  64  PC of the instruction in M.
- M_pred_taken_i  in  1  prediction made for that instruction at fetch.
- M_valC_i  in  64  jump target carried to M.
- M_valA_i  in  64  fall-through PC carried to M.
- M_mispred_o  out  1  jXX in M was mispredicted.
- M_redirect_pc_o  out  64  correct PC after a mispredict.
- br_cnt_o  out  32  number of resolved jXX.
- mispred_cnt_o  out  32  number of mispredicts.

Behaviour:
- Icodes: IJXX=4'h7, ICALL=4'h8; all others are non-control for this block. IRET is handled downstream in PC select and is not predicted here.
- BHT index:
  - fetch side: f_pc_i[IDX_W-1:0]
  - update side: M_pc_i[IDX_W-1:0]
  - Byte-granular PCs, no shift; aliasing is permitted.
- Counter encoding: 0 strong-NT, 1 weak-NT, 2 weak-T, 3 strong-T. Predict taken iff counter[1]=1.
- Prediction (combinational):
  - f_pred_taken_o = (f_icode_i==IJXX) & BHT[f_idx][1]; otherwise 0.
  - next_pred = f_valC_i if ICALL, or if IJXX and f_pred_taken_o; otherwise f_valP_i.
- F_predPC register:
  - rst_i → RESET_PC.
  - else if !F_stall_i → next_pred.
  - else hold.
  - One-cycle latency from fetch inputs to F_predPC_o.
- Training, on each cycle with M_icode_i==IJXX and !rst_i:
  - M_Cnd_i=1 → counter+1, saturating at 3.
  - M_Cnd_i=0 → counter−1, saturating at 0.
  - Exactly one update per cycle. A bubble in M (non-IJXX icode) causes no update.
- Same-index read/write in one cycle: the fetch lookup sees the pre-update value; no bypass. The new value is visible next cycle.
- Mispredict (combinational):
  - M_mispred_o = (M_icode_i==IJXX) & (M_Cnd_i != M_pred_taken_i).
  - M_redirect_pc_o = M_Cnd_i ? M_valC_i : M_valA_i. This output is driven for every IJXX; it is don't-care otherwise.
- Statistics counters:
  - rst_i → 0.
  - br_cnt_o += 1 on each resolved IJXX.
  - mispred_cnt_o += 1 when M_mispred_o.
  - Both saturate at 32'hFFFF_FFFF; no wrap.
- Reset:
  - All BHT entries → 2 (weak-T), which matches the legacy always-taken policy.
  - F_predPC_o=RESET_PC, counters=0.
  - Reset mid-operation discards all training on the next edge. With rst_i high, no training or count update occurs in that cycle.
- F_stall_i affects only F_predPC. BHT training and statistics proceed during fetch stalls.
- Outputs are combinational from inputs and state only; no X propagation from an uninitialised BHT (reset covers every entry).

Test Plan:
- Reset, then fetch IJXX at f_pc=0x10, valC=0x40, valP=0x19 → f_pred_taken_o=1; F_predPC_o=0x40 next cycle; F_predPC_o=0 during reset.
- Resolve IJXX at M_pc=0x10 with Cnd=0 twice → entry 0x10 goes 2→1→0. The next fetch at 0x10 predicts NT, F_predPC=0x19; br_cnt=2, mispred_cnt=1 if the first had pred_taken=1.
- Mispredict at M: pred_taken=0, Cnd=1, valC=0x80, valA=0x29 → M_mispred_o=1, M_redirect_pc_o=0x80. Reversed case (pred_taken=1, Cnd=0) → redirect=0x29.
- F_stall_i=1 for 3 cycles while fetch inputs change → F_predPC_o holds. A jXX resolving during the stall still updates the BHT and br_cnt.
- Same-cycle fetch and update on index 0x10 (counter=1, Cnd=1) → fetch predicts NT that cycle; the counter reads 2 (predicts T) the following cycle.
- Four Cnd=1 updates from counter=2 → saturates at 3. Preload mispred_cnt near max via a long run → holds at 32'hFFFF_FFFF. Mid-run rst_i pulse restores all entries to 2 and clears the counters.
